mod_greeter: RTL and testbench

//  Multi-channel external request handler for Iroha-generated designs. Accepts valid/ready

---
 rtl/mod_greeter_pkg.sv | 13 +
 rtl/mod_greeter_rr_arb.sv | 33 +++
 rtl/mod_greeter.sv | 109 ++++++++++
 tb/tb_mod_greeter.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/mod_greeter_pkg.sv
// rtl/mod_greeter_pkg.sv - shared FSM state type and channel-index width helper for mod_greeter
package mod_greeter_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACK  = 1'b1
    } state_t;

    function automatic int ch_w(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

endpackage

// File: rtl/mod_greeter_rr_arb.sv
// rtl/mod_greeter_rr_arb.sv - combinational round-robin grant over an eligible mask
module mod_greeter_rr_arb
    import mod_greeter_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CH_W   = ch_w(NUM_CH)
) (
    input  logic [NUM_CH-1:0] eligible,
    input  logic [CH_W-1:0]   ptr,
    output logic [NUM_CH-1:0] grant_oh,
    output logic [CH_W-1:0]   grant_idx,
    output logic              any_grant
);

    logic [CH_W-1:0] cand;

    // Scan channels starting at the pointer; the first eligible one wins.
    always_comb begin
        grant_oh  = '0;
        grant_idx = '0;
        any_grant = 1'b0;
        cand      = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            cand = CH_W'((int'(ptr) + i) % NUM_CH);
            if (!any_grant && eligible[cand]) begin
                any_grant      = 1'b1;
                grant_oh[cand] = 1'b1;
                grant_idx      = cand;
            end
        end
    end

endmodule

// File: rtl/mod_greeter.sv
// rtl/mod_greeter.sv - round-robin request handler with first-contact tracking; MOD_GREETER_DISPLAY_EN enables greeting print
module mod_greeter
    import mod_greeter_pkg::*;
#(
    parameter int NUM_CH  = 4,
    parameter int DATA_W  = 8,
    parameter int COUNT_W = 16,
    parameter bit ONCE    = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_CH-1:0]          req_valid,
    input  logic [NUM_CH*DATA_W-1:0]   req_data,
    output logic [NUM_CH-1:0]          req_ready,
    output logic                       out_valid,
    output logic [$clog2(NUM_CH)-1:0]  out_ch,
    output logic [DATA_W-1:0]          out_data,
    output logic                       out_first,
    output logic [COUNT_W-1:0]         total_count
);

    localparam int CH_W = ch_w(NUM_CH);

    state_t              state;
    state_t              state_next;
    logic [CH_W-1:0]     ptr;
    logic [NUM_CH-1:0]   seen;
    logic [NUM_CH-1:0]   ack_mask;
    logic [NUM_CH-1:0]   eligible;
    logic [NUM_CH-1:0]   grant_oh;
    logic [CH_W-1:0]     grant_idx;
    logic                any_grant;
    logic [DATA_W-1:0]   grant_data;
    logic                grant_seen;

    // A channel being acked this cycle still shows valid; mask it so it is not re-granted.
    assign ack_mask = (state == ST_ACK) ? req_ready : '0;
    assign eligible = req_valid & ~ack_mask;

    mod_greeter_rr_arb #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W)
    ) u_arb (
        .eligible  (eligible),
        .ptr       (ptr),
        .grant_oh  (grant_oh),
        .grant_idx (grant_idx),
        .any_grant (any_grant)
    );

    assign grant_data = req_data[grant_idx*DATA_W +: DATA_W];
    assign grant_seen = seen[grant_idx];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (any_grant) state_next = ST_ACK;
            ST_ACK:  state_next = any_grant ? ST_ACK : ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_ready   <= '0;
            out_valid   <= 1'b0;
            out_ch      <= '0;
            out_data    <= '0;
            out_first   <= 1'b0;
            total_count <= '0;
            seen        <= '0;
            ptr         <= '0;
        end else if (any_grant) begin
            req_ready   <= grant_oh;
            out_valid   <= !(ONCE && grant_seen);
            out_ch      <= grant_idx;
            out_data    <= grant_data;
            out_first   <= !grant_seen;
            seen        <= seen | grant_oh;
            ptr         <= (grant_idx == CH_W'(NUM_CH - 1)) ? '0 : grant_idx + 1'b1;
            if (total_count != '1) begin
                total_count <= total_count + 1'b1;
            end
        end else begin
            req_ready   <= '0;
            out_valid   <= 1'b0;
            out_ch      <= '0;
            out_data    <= '0;
            out_first   <= 1'b0;
        end
    end

`ifdef MOD_GREETER_DISPLAY_EN
    always_ff @(posedge clk) begin
        if (!rst && any_grant && !grant_seen) begin
            $display("Hello world! ch=%0d data=%h", grant_idx, grant_data);
        end
    end
`endif

endmodule

// File: tb/tb_mod_greeter.sv
// tb/tb_mod_greeter.sv - directed self-checking bench for mod_greeter (ONCE=1 wide counter, ONCE=0 two-bit counter)
module tb_mod_greeter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [31:0] req_data;

    logic [3:0]  a_ready;
    logic        a_valid;
    logic [1:0]  a_ch;
    logic [7:0]  a_data;
    logic        a_first;
    logic [15:0] a_count;

    logic [3:0]  b_ready;
    logic        b_valid;
    logic [1:0]  b_ch;
    logic [7:0]  b_data;
    logic        b_first;
    logic [1:0]  b_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mod_greeter #(.NUM_CH(4), .DATA_W(8), .COUNT_W(16), .ONCE(1'b1)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ready   (a_ready),
        .out_valid   (a_valid),
        .out_ch      (a_ch),
        .out_data    (a_data),
        .out_first   (a_first),
        .total_count (a_count)
    );

    mod_greeter #(.NUM_CH(4), .DATA_W(8), .COUNT_W(2), .ONCE(1'b0)) dut_b (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ready   (b_ready),
        .out_valid   (b_valid),
        .out_ch      (b_ch),
        .out_data    (b_data),
        .out_first   (b_first),
        .total_count (b_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_data(input int ch, input logic [7:0] d);
        req_data[ch*8 +: 8] = d;
    endtask

    task automatic check_a(input string tag, input logic [3:0] rdy, input logic vld,
                           input logic [1:0] ch, input logic [7:0] d, input logic first,
                           input logic [15:0] cnt);
        check({tag, ".a_ready"}, 32'(a_ready), 32'(rdy));
        check({tag, ".a_valid"}, 32'(a_valid), 32'(vld));
        check({tag, ".a_ch"},    32'(a_ch),    32'(ch));
        check({tag, ".a_data"},  32'(a_data),  32'(d));
        check({tag, ".a_first"}, 32'(a_first), 32'(first));
        check({tag, ".a_count"}, 32'(a_count), 32'(cnt));
    endtask

    task automatic check_b(input string tag, input logic [3:0] rdy, input logic vld,
                           input logic first, input logic [1:0] cnt);
        check({tag, ".b_ready"}, 32'(b_ready), 32'(rdy));
        check({tag, ".b_valid"}, 32'(b_valid), 32'(vld));
        check({tag, ".b_first"}, 32'(b_first), 32'(first));
        check({tag, ".b_count"}, 32'(b_count), 32'(cnt));
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = 4'b0000;
        req_data  = 'x;
        repeat (2) @(negedge clk);
        check_a("reset", 4'b0000, 1'b0, 2'd0, 8'h00, 1'b0, 16'd0);
        check_b("reset", 4'b0000, 1'b0, 1'b0, 2'd0);

        // Reset asserted just after a grant registers clears everything.
        rst       = 1'b0;
        req_valid = 4'b0001;
        set_data(0, 8'h11);
        @(posedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        check_a("rst_mid", 4'b0000, 1'b0, 2'd0, 8'h00, 1'b0, 16'd0);
        req_valid = 4'b0000;
        req_data  = 'x;
        @(negedge clk);
        check_a("rst_hold", 4'b0000, 1'b0, 2'd0, 8'h00, 1'b0, 16'd0);
        rst = 1'b0;

        // Single request on ch2.
        req_valid = 4'b0100;
        set_data(2, 8'h5A);
        @(negedge clk);
        check_a("single", 4'b0100, 1'b1, 2'd2, 8'h5A, 1'b1, 16'd1);
        check_b("single", 4'b0100, 1'b1, 1'b1, 2'd1);
        req_valid = 4'b0000;
        req_data  = 'x;
        @(negedge clk);
        check_a("idle1", 4'b0000, 1'b0, 2'd0, 8'h00, 1'b0, 16'd1);

        // Repeat on ch2: suppressed on the ONCE instance.
        req_valid = 4'b0100;
        set_data(2, 8'h33);
        @(negedge clk);
        check_a("repeat", 4'b0100, 1'b0, 2'd2, 8'h33, 1'b0, 16'd2);
        check_b("repeat", 4'b0100, 1'b1, 1'b0, 2'd2);
        req_valid = 4'b0000;
        req_data  = 'x;

        // ch3 brings the pointer back to 0; two-bit counter reaches 3.
        req_valid = 4'b1000;
        set_data(3, 8'h77);
        @(negedge clk);
        check_a("ch3", 4'b1000, 1'b1, 2'd3, 8'h77, 1'b1, 16'd3);
        check_b("ch3", 4'b1000, 1'b1, 1'b1, 2'd3);

        // All four at once: ch0..ch3 in consecutive cycles.
        req_valid = 4'b1111;
        set_data(0, 8'hA0);
        set_data(1, 8'hA1);
        set_data(2, 8'hA2);
        set_data(3, 8'hA3);
        @(negedge clk);
        check_a("all0", 4'b0001, 1'b1, 2'd0, 8'hA0, 1'b1, 16'd4);
        check_b("all0", 4'b0001, 1'b1, 1'b1, 2'd3);
        req_valid = 4'b1110;
        @(negedge clk);
        check_a("all1", 4'b0010, 1'b1, 2'd1, 8'hA1, 1'b1, 16'd5);
        check_b("all1", 4'b0010, 1'b1, 1'b1, 2'd3);
        req_valid = 4'b1100;
        @(negedge clk);
        check_a("all2", 4'b0100, 1'b0, 2'd2, 8'hA2, 1'b0, 16'd6);
        check_b("all2", 4'b0100, 1'b1, 1'b0, 2'd3);
        req_valid = 4'b1000;
        @(negedge clk);
        check_a("all3", 4'b1000, 1'b0, 2'd3, 8'hA3, 1'b0, 16'd7);
        check_b("all3", 4'b1000, 1'b1, 1'b0, 2'd3);
        req_valid = 4'b0000;
        req_data  = 'x;

        // Pointer wrapped to 0: ch0 beats ch1.
        req_valid = 4'b0011;
        set_data(0, 8'h01);
        set_data(1, 8'h02);
        @(negedge clk);
        check_a("wrap", 4'b0001, 1'b0, 2'd0, 8'h01, 1'b0, 16'd8);

        // ch1 held high: acked every other cycle.
        req_valid = 4'b0010;
        @(negedge clk);
        check_a("hold1", 4'b0010, 1'b0, 2'd1, 8'h02, 1'b0, 16'd9);
        check_b("hold1", 4'b0010, 1'b1, 1'b0, 2'd3);
        @(negedge clk);
        check_a("hold2", 4'b0000, 1'b0, 2'd0, 8'h00, 1'b0, 16'd9);
        @(negedge clk);
        check_a("hold3", 4'b0010, 1'b0, 2'd1, 8'h02, 1'b0, 16'd10);
        check_b("hold3", 4'b0010, 1'b1, 1'b0, 2'd3);
        @(negedge clk);
        check_a("hold4", 4'b0000, 1'b0, 2'd0, 8'h00, 1'b0, 16'd10);
        req_valid = 4'b0000;
        req_data  = 'x;
        @(negedge clk);
        check_a("final", 4'b0000, 1'b0, 2'd0, 8'h00, 1'b0, 16'd10);
        check_b("final", 4'b0000, 1'b0, 1'b0, 2'd3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
